code_serializer: RTL and testbench

CODE_SERIALIZER -- requirements
Module: code_serializer

---
 rtl/fsm_pkg.sv | 29 ++
 rtl/code_serializer.sv | 139 +++++++++++++
 tb/tb_code_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the code serializer.
// Contents:
//   state_t        : IDLE / SHIFT / GAP state encoding
//   DATA_W, LEN_W  : code data width (8) and length field width (4)
//   DEF_IDLE_LEVEL : default line level when no code bit is being sent
//   DEF_GAP_CYCLES : default number of idle cycles after each frame
//   clamp_len()    : maps a raw load length onto the legal range 0..DATA_W
package fsm_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned LEN_W          = 4;
  localparam bit          DEF_IDLE_LEVEL = 1'b1;
  localparam int unsigned DEF_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Lengths above DATA_W saturate to DATA_W.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DATA_W)) begin
      return LEN_W'(DATA_W);
    end
    return len;
  endfunction

endpackage

// File: rtl/code_serializer.sv
// Serializes a 1..8 bit code onto a single registered line, MSB of the
// selected field first, followed by a fixed number of idle gap cycles.
//
// Handshake: a load is taken on a posedge where load_valid and load_ready
// are both 1. load_ready is 1 exactly when the FSM is in IDLE; load_data and
// load_len are sampled only on that edge and ignored afterwards.
//
// Ports:
//   clk         : clock, all state updates on posedge
//   Reset       : asynchronous active-high reset
//   load_valid  : load request
//   load_ready  : block can accept a load this cycle
//   load_data   : code bits, bit (len-1) sent first
//   load_len    : number of bits to send (9..15 treated as 8)
//   a           : registered serial output, IDLE_LEVEL when not sending
//   busy        : state is SHIFT or GAP
//   done        : one-cycle pulse after the last bit (or after a len-0 load)
//   o_dbg_state : current FSM state, for observation only
module code_serializer
  import fsm_pkg::*;
#(
  parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              a,
  output logic              busy,
  output logic              done,
  output state_t            o_dbg_state
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [LEN_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_gap;
  logic                r_a;
  logic                r_done;

  state_t              w_state_next;
  logic [DATA_W-1:0]   w_shift_next;
  logic [LEN_W-1:0]    w_cnt_next;
  logic [LEN_W-1:0]    w_gap_next;
  logic                w_a_next;
  logic                w_done_next;
  logic                w_accept;
  logic [LEN_W-1:0]    w_eff_len;
  logic [2:0]          w_first_idx;

  assign w_eff_len   = clamp_len(load_len);
  assign w_first_idx = 3'(w_eff_len - 4'd1);
  assign load_ready  = (r_state == ST_IDLE);
  assign w_accept    = load_valid && load_ready;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
    w_a_next     = IDLE_LEVEL;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_eff_len == '0) begin
            // Empty code: stay idle, just report completion.
            w_done_next = 1'b1;
          end else begin
            // The first bit goes straight to the output register; the
            // remaining N-1 bits are left-aligned in the shift register.
            w_state_next = ST_SHIFT;
            w_a_next     = load_data[w_first_idx];
            w_shift_next = load_data << (4'd9 - w_eff_len);
            w_cnt_next   = w_eff_len;
          end
        end
      end
      ST_SHIFT: begin
        // r_cnt holds the bits still to appear including the current one.
        if (r_cnt == 4'd1) begin
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
          w_shift_next = '0;
          if (GAP_CYCLES == 0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_GAP;
            w_gap_next   = LEN_W'(GAP_CYCLES);
          end
        end else begin
          w_a_next     = r_shift[DATA_W-1];
          w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      ST_GAP: begin
        if (r_gap <= 4'd1) begin
          w_state_next = ST_IDLE;
          w_gap_next   = '0;
        end else begin
          w_gap_next = r_gap - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_gap_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_a     <= IDLE_LEVEL;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_gap   <= w_gap_next;
      r_a     <= w_a_next;
      r_done  <= w_done_next;
    end
  end

  assign a           = r_a;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_code_serializer.sv
module tb_code_serializer;
  import fsm_pkg::*;

  logic       clk;
  logic       rst;

  // Instance 0: default GAP_CYCLES=2
  logic       lv0, lr0, a0, busy0, done0;
  logic [7:0] ld0;
  logic [3:0] ll0;
  state_t     st0;

  // Instance 1: GAP_CYCLES=0
  logic       lv1, lr1, a1, busy1, done1;
  logic [7:0] ld1;
  logic [3:0] ll1;
  state_t     st1;

  int n_checks = 0;
  int n_errors = 0;

  code_serializer #(.IDLE_LEVEL(1'b1), .GAP_CYCLES(2)) dut0 (
    .clk(clk), .Reset(rst), .load_valid(lv0), .load_ready(lr0),
    .load_data(ld0), .load_len(ll0), .a(a0), .busy(busy0), .done(done0),
    .o_dbg_state(st0)
  );

  code_serializer #(.IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .Reset(rst), .load_valid(lv1), .load_ready(lr1),
    .load_data(ld1), .load_len(ll1), .a(a1), .busy(busy1), .done(done1),
    .o_dbg_state(st1)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [7:0] exp_bits;  // expected bits left-aligned, first bit at [7]
    int         n;         // expected number of bits sent
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Checks n bit cycles of dut0, starting in the cycle after acceptance.
  task automatic frame_bits(input logic [7:0] exp_bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d a", tag, i), a0, exp_bits[7-i]);
      chk($sformatf("%s bit%0d busy", tag, i), busy0, 1'b1);
      chk($sformatf("%s bit%0d done", tag, i), done0, 1'b0);
      chk($sformatf("%s bit%0d ready", tag, i), lr0, 1'b0);
    end
  endtask

  // Two gap cycles then IDLE, done only in the first gap cycle.
  task automatic tail_gap2(input string tag);
    @(negedge clk);
    chk({tag, " gap1 done"}, done0, 1'b1);
    chk({tag, " gap1 a"}, a0, 1'b1);
    chk({tag, " gap1 busy"}, busy0, 1'b1);
    chk({tag, " gap1 ready"}, lr0, 1'b0);
    @(negedge clk);
    chk({tag, " gap2 done"}, done0, 1'b0);
    chk({tag, " gap2 a"}, a0, 1'b1);
    chk({tag, " gap2 busy"}, busy0, 1'b1);
    chk({tag, " gap2 ready"}, lr0, 1'b0);
    @(negedge clk);
    chk({tag, " idle ready"}, lr0, 1'b1);
    chk({tag, " idle busy"}, busy0, 1'b0);
    chk({tag, " idle done"}, done0, 1'b0);
    chk({tag, " idle a"}, a0, 1'b1);
  endtask

  // driver: one load on dut0, then checks of the full frame
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    lv0 = 1'b1;
    ld0 = v.data;
    ll0 = v.len;
    @(posedge clk);
    #1;
    lv0 = 1'b0;
    ld0 = ~v.data;   // must be ignored after acceptance
    ll0 = 4'd7;
    if (v.n == 0) begin
      @(negedge clk);
      chk({tag, " len0 done"}, done0, 1'b1);
      chk({tag, " len0 busy"}, busy0, 1'b0);
      chk({tag, " len0 a"}, a0, 1'b1);
      chk({tag, " len0 ready"}, lr0, 1'b1);
      chk({tag, " len0 state idle"}, st0 == ST_IDLE, 1'b1);
      @(negedge clk);
      chk({tag, " len0 done drop"}, done0, 1'b0);
      chk({tag, " len0 busy2"}, busy0, 1'b0);
    end else begin
      frame_bits(v.exp_bits, v.n, tag);
      tail_gap2(tag);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h0B, len: 4'd5,  exp_bits: 8'b0101_1000, n: 5};
    vecs[1] = '{data: 8'hA5, len: 4'd12, exp_bits: 8'b1010_0101, n: 8};
    vecs[2] = '{data: 8'h5A, len: 4'd0,  exp_bits: 8'b0000_0000, n: 0};
    vecs[3] = '{data: 8'hFF, len: 4'd1,  exp_bits: 8'b1000_0000, n: 1};
    vecs[4] = '{data: 8'h00, len: 4'd3,  exp_bits: 8'b0000_0000, n: 3};
    vecs[5] = '{data: 8'h96, len: 4'd8,  exp_bits: 8'b1001_0110, n: 8};
    vecs[6] = '{data: 8'h3C, len: 4'd15, exp_bits: 8'b0011_1100, n: 8};
    vecs[7] = '{data: 8'h02, len: 4'd2,  exp_bits: 8'b1000_0000, n: 2};
    vecs[8] = '{data: 8'hF0, len: 4'd4,  exp_bits: 8'b0000_0000, n: 4};

    // reset
    rst = 1'b1;
    lv0 = 1'b0; ld0 = '0; ll0 = '0;
    lv1 = 1'b0; ld1 = '0; ll1 = '0;
    repeat (3) @(negedge clk);
    chk("reset a0", a0, 1'b1);
    chk("reset busy0", busy0, 1'b0);
    chk("reset done0", done0, 1'b0);
    chk("reset ready0", lr0, 1'b1);
    chk("reset a1", a1, 1'b1);
    chk("reset ready1", lr1, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // table-driven frames
    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // mid-frame reset during the 3rd bit
    @(negedge clk);
    lv0 = 1'b1; ld0 = 8'h0B; ll0 = 4'd5;
    @(posedge clk);
    #1;
    lv0 = 1'b0;
    @(negedge clk);
    chk("rst frame bit0", a0, 1'b0);
    @(negedge clk);
    chk("rst frame bit1", a0, 1'b1);
    @(negedge clk);
    chk("rst frame bit2", a0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst async a", a0, 1'b1);
    chk("rst async busy", busy0, 1'b0);
    chk("rst async ready", lr0, 1'b1);
    chk("rst async done", done0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post rst no done %0d", i), done0, 1'b0);
      chk($sformatf("post rst idle %0d", i), busy0, 1'b0);
      chk($sformatf("post rst a %0d", i), a0, 1'b1);
    end
    run_vec(vecs[0], "after rst");

    // two queued codes with load_valid held high (GAP_CYCLES=2)
    @(negedge clk);
    lv0 = 1'b1; ld0 = 8'h0B; ll0 = 4'd5;
    @(posedge clk);
    #1;
    ld0 = 8'hC3; ll0 = 4'd4;
    frame_bits(8'b0101_1000, 5, "q1");
    @(negedge clk);
    chk("q done", done0, 1'b1);
    chk("q gap1 ready", lr0, 1'b0);
    @(negedge clk);
    chk("q gap2 ready", lr0, 1'b0);
    @(negedge clk);
    chk("q idle ready", lr0, 1'b1);
    chk("q idle busy", busy0, 1'b0);
    @(posedge clk);
    #1;
    lv0 = 1'b0;
    frame_bits(8'b0011_0000, 4, "q2");
    tail_gap2("q2");

    // GAP_CYCLES=0 instance, back-to-back loads
    @(negedge clk);
    lv1 = 1'b1; ld1 = 8'h05; ll1 = 4'd3;
    @(posedge clk);
    #1;
    ld1 = 8'h02; ll1 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("g0 f1 bit%0d", i), a1, (i != 1));
      chk($sformatf("g0 f1 busy%0d", i), busy1, 1'b1);
      chk($sformatf("g0 f1 ready%0d", i), lr1, 1'b0);
      chk($sformatf("g0 f1 done%0d", i), done1, 1'b0);
    end
    @(negedge clk);
    chk("g0 f1 done", done1, 1'b1);
    chk("g0 f1 ready", lr1, 1'b1);
    chk("g0 idle a", a1, 1'b1);
    chk("g0 idle busy", busy1, 1'b0);
    @(posedge clk);
    #1;
    lv1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("g0 f2 bit%0d", i), a1, (i == 0));
      chk($sformatf("g0 f2 busy%0d", i), busy1, 1'b1);
      chk($sformatf("g0 f2 done%0d", i), done1, 1'b0);
    end
    @(negedge clk);
    chk("g0 f2 done", done1, 1'b1);
    chk("g0 f2 ready", lr1, 1'b1);
    chk("g0 f2 a idle", a1, 1'b1);
    @(negedge clk);
    chk("g0 f2 done drop", done1, 1'b0);
    chk("g0 f2 stays idle", busy1, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
